sram_controller: RTL and testbench

Sequencer between the pipeline's memory stage and a 16-bit asynchronous external SRAM. It accepts one 32-bit word read or write per request and splits it into two 16-bit SRAM half-accesses with a programmable number of wait cycles. It drives `ready` low while a transaction is in flight; the top level inverts it to form `freeze_MEM`, which stalls IF/ID/EXE/MEM registers. The data-memory window starts at byte address `BASE_ADDR`.

---
 rtl/sram_controller_pkg.sv | 17 +
 rtl/sram_controller_wait_counter.sv | 37 +++
 rtl/sram_controller.sv | 146 ++++++++++++++
 tb/tb_sram_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared state encoding and default geometry for the external SRAM sequencer.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int SRAM_ADDR_LEN_DEF = 18;
    localparam int SRAM_DATA_LEN_DEF = 16;
    localparam int BASE_ADDR_DEF     = 1024;
    localparam int WAIT_CYCLES_DEF   = 1;
    localparam int CNT_W             = 3;

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Phase counter: counts 0..WAIT_CYCLES+1 and wraps, flagging the final and next-to-final cycle.
module sram_wait_counter
    import sram_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             penult_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o    = cnt_q;
    assign last_o   = (cnt_q == LAST);
    assign penult_o = (cnt_q == LAST - 1'b1);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline access into two 16-bit SRAM half-accesses (LO then HI),
// stalling the pipeline through ready until the DONE cycle.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int ADDR_LEN      = 32,
    parameter int DATA_LEN      = 32,
    parameter int SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF,
    parameter int SRAM_DATA_LEN = SRAM_DATA_LEN_DEF,
    parameter int WAIT_CYCLES   = WAIT_CYCLES_DEF,
    parameter int BASE_ADDR     = BASE_ADDR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDR_LEN-1:0]      address,
    input  logic [DATA_LEN-1:0]      write_data,
    output logic [DATA_LEN-1:0]      read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    output logic                     sram_dq_oe,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_we_n,
    output logic                     sram_oe_n,
    output logic                     sram_ub_n,
    output logic                     sram_lb_n
);

    localparam int WW = SRAM_ADDR_LEN - 1;

    state_e                   state_q, state_d;
    logic                     op_wr_q, op_wr_d;
    logic [WW-1:0]            word_q, word_d;
    logic [DATA_LEN-1:0]      wdata_q, wdata_d;
    logic [DATA_LEN-1:0]      rdata_q, rdata_d;
    logic [SRAM_ADDR_LEN-1:0] addr_q, addr_d;
    logic [SRAM_DATA_LEN-1:0] dq_q, dq_d;
    logic                     dq_oe_q, dq_oe_d;
    logic                     we_n_q, we_n_d;
    logic                     oe_n_q, oe_n_d;

    logic [CNT_W-1:0] cnt;
    logic             last, penult;
    logic             req, in_phase, start, to_hi, enter, wr_sel;
    logic [WW-1:0]    word_in;

    // Word index of the byte offset from the window base; upper bits drop so addresses wrap.
    assign word_in  = WW'((address - ADDR_LEN'(BASE_ADDR)) >> 2);
    assign req      = wr_en | rd_en;
    assign in_phase = (state_q == ST_LO) || (state_q == ST_HI);
    assign start    = (state_q == ST_IDLE) && req;
    assign to_hi    = (state_q == ST_LO) && last;
    assign enter    = start || to_hi;
    assign wr_sel   = (state_q == ST_IDLE) ? wr_en : op_wr_q;

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (~in_phase),
        .en_i     (in_phase),
        .cnt_o    (cnt),
        .last_o   (last),
        .penult_o (penult)
    );

    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        dq_d    = dq_q;
        dq_oe_d = 1'b0;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;

        case (state_q)
            ST_IDLE: if (req) begin
                state_d = ST_LO;
                op_wr_d = wr_en;
                word_d  = word_in;
                wdata_d = write_data;
            end
            ST_LO:   if (last) state_d = ST_HI;
            ST_HI:   if (last) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        if (enter) begin
            addr_d = {start ? word_in : word_q, to_hi};
            dq_d   = start ? write_data[SRAM_DATA_LEN-1:0] : wdata_q[DATA_LEN-1:SRAM_DATA_LEN];
        end

        // Bus controls are registered, so they are decoded for the cycle about to begin.
        if (enter || (in_phase && !last)) begin
            dq_oe_d = wr_sel;
            oe_n_d  = wr_sel;
            we_n_d  = ~(wr_sel & (enter | ~penult));
        end

        if (in_phase && last && !op_wr_q) begin
            if (state_q == ST_LO) rdata_d[SRAM_DATA_LEN-1:0]        = sram_dq_in;
            else                  rdata_d[DATA_LEN-1:SRAM_DATA_LEN] = sram_dq_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            dq_oe_q <= dq_oe_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    assign ready       = ~(req & (state_q != ST_DONE));
    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_ub_n   = 1'b0;
    assign sram_lb_n   = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench: two controllers (WAIT_CYCLES=1 and 0) on behavioural SRAMs that write on the we_n rising edge.
module tb_sram_controller;

    localparam int P   = 3;
    localparam int LEN = 2 * P + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wr1, rd1, ready1, dqoe1, wen1, oen1, ub1, lb1;
    logic [31:0] addr1, wd1, rdata1;
    logic [17:0] sa1;
    logic [15:0] dqo1, dqi1;
    logic        wr0, rd0, ready0, dqoe0, wen0, oen0, ub0, lb0;
    logic [31:0] addr0, wd0, rdata0;
    logic [17:0] sa0;
    logic [15:0] dqo0, dqi0;

    sram_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1), .write_data(wd1),
        .read_data(rdata1), .ready(ready1), .sram_addr(sa1), .sram_dq_out(dqo1),
        .sram_dq_oe(dqoe1), .sram_dq_in(dqi1), .sram_we_n(wen1), .sram_oe_n(oen1),
        .sram_ub_n(ub1), .sram_lb_n(lb1));

    sram_controller #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(addr0), .write_data(wd0),
        .read_data(rdata0), .ready(ready0), .sram_addr(sa0), .sram_dq_out(dqo0),
        .sram_dq_oe(dqoe0), .sram_dq_in(dqi0), .sram_we_n(wen0), .sram_oe_n(oen0),
        .sram_ub_n(ub0), .sram_lb_n(lb0));

    // SRAM models: address/data are taken while we_n is low and committed on its rising edge.
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem0 [0:262143];
    logic [17:0] wa1, wa0;
    logic [15:0] wq1, wq0;
    assign dqi1 = oen1 ? 16'h0 : mem1[sa1];
    assign dqi0 = oen0 ? 16'h0 : mem0[sa0];
    always @(negedge clk) if (!wen1) begin wa1 = sa1; wq1 = dqo1; end
    always @(negedge clk) if (!wen0) begin wa0 = sa0; wq0 = dqo0; end
    always @(posedge wen1) mem1[wa1] = wq1;
    always @(posedge wen0) mem0[wa0] = wq0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] wordof(input logic [31:0] a);
        logic [31:0] o;
        o = a - 32'd1024;
        return 17'((o / 4) % 131072);
    endfunction

    // Transaction-level model: mk = cycles since acceptance (0 = idle, LEN = done cycle).
    int          mk;
    logic        mwr;
    logic [16:0] mword;
    logic [31:0] mdata, rd_cur, rd_next;
    logic [31:0] ref_mem [int];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk = 0; rd_cur = 0;
        end else if (mk == 0) begin
            if (wr1 | rd1) begin
                mwr = wr1; mword = wordof(addr1); mdata = wd1;
                if (wr1) ref_mem[int'(mword)] = wd1;
                else     rd_next = ref_mem.exists(int'(mword)) ? ref_mem[int'(mword)] : 32'h0;
                mk = 1;
            end
        end else if (mk < LEN) begin
            mk++;
        end else begin
            mk = 0;
            if (!mwr) rd_cur = rd_next;
        end
    end

    always @(negedge clk) begin : compare
        logic ph, hi;
        int c;
        logic [31:0] erd;
        chk("ublb", 32'({ub1, lb1}), 32'h0);
        if (rst) begin
            chk("rst_ready", 32'(ready1), 32'(!(wr1 | rd1)));
            chk("rst_we_n", 32'(wen1), 32'h1);
            chk("rst_oe_n", 32'(oen1), 32'h1);
            chk("rst_dq_oe", 32'(dqoe1), 32'h0);
            chk("rst_addr", 32'(sa1), 32'h0);
            chk("rst_dq_out", 32'(dqo1), 32'h0);
            chk("rst_rdata", rdata1, 32'h0);
        end else begin
            ph = (mk >= 1) && (mk <= 2 * P);
            hi = (mk > P);
            c  = (mk - 1) % P;
            chk("ready", 32'(ready1), 32'(!((wr1 | rd1) && mk != LEN)));
            chk("we_n", 32'(wen1), 32'(!(ph && mwr && c != P - 1)));
            chk("oe_n", 32'(oen1), 32'(!(ph && !mwr)));
            chk("dq_oe", 32'(dqoe1), 32'(ph && mwr));
            if (ph) chk("sram_addr", 32'(sa1), 32'({mword, hi}));
            if (ph && mwr) chk("dq_out", 32'(dqo1), 32'(hi ? mdata[31:16] : mdata[15:0]));
            if (!mwr && mk == LEN)     erd = rd_next;
            else if (!mwr && mk > P)   erd = {rd_cur[31:16], rd_next[15:0]};
            else                       erd = rd_cur;
            chk("read_data", rdata1, erd);
        end
    end

    logic        g_rdy [0:7], g_we [0:7], g_oe [0:7], g_dqoe [0:7];
    logic [17:0] g_a   [0:7];
    logic [15:0] g_dq  [0:7];
    logic [31:0] g_rd  [0:7];

    task automatic grab1();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g_rdy[k] = ready1; g_we[k] = wen1; g_oe[k] = oen1; g_dqoe[k] = dqoe1;
            g_a[k] = sa1; g_dq[k] = dqo1; g_rd[k] = rdata1;
        end
    endtask

    task automatic grab0();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g_rdy[k] = ready0; g_we[k] = wen0; g_oe[k] = oen0; g_dqoe[k] = dqoe0;
            g_a[k] = sa0; g_dq[k] = dqo0; g_rd[k] = rdata0;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready1();
        int n = 0;
        do begin @(negedge clk); n++; end while (!ready1 && n < 40);
        chk("ready_wait", 32'(ready1), 32'h1);
    endtask

    initial begin
        int lo_low, hi_low, oe_low, dqoe_sum;
        wr1 = 0; rd1 = 0; addr1 = 0; wd1 = 0;
        wr0 = 0; rd0 = 0; addr0 = 0; wd0 = 0;
        rst = 1;
        for (int i = 0; i < 262144; i++) begin mem1[i] = 16'h0; mem0[i] = 16'h0; end

        @(negedge clk);
        chk("lit_rst_ready", 32'(ready1), 32'h1);
        rd1 = 1; #1;
        chk("lit_rst_ready_req", 32'(ready1), 32'h0);
        rd1 = 0;
        step(); rst = 0;
        step();

        // Write 0xDEADBEEF at 1032 -> SRAM words 4 and 5.
        wr1 = 1; addr1 = 32'd1032; wd1 = 32'hDEADBEEF;
        grab1();
        lo_low = 0; hi_low = 0; dqoe_sum = 0;
        for (int k = 1; k <= 3; k++) lo_low += int'(!g_we[k]);
        for (int k = 4; k <= 6; k++) hi_low += int'(!g_we[k]);
        for (int k = 1; k <= 6; k++) dqoe_sum += int'(g_dqoe[k]);
        chk("lit_wr_addr_lo", 32'(g_a[1]), 32'd4);
        chk("lit_wr_dq_lo", 32'(g_dq[1]), 32'hBEEF);
        chk("lit_wr_addr_hi", 32'(g_a[4]), 32'd5);
        chk("lit_wr_dq_hi", 32'(g_dq[4]), 32'hDEAD);
        chk("lit_wr_we_lo", 32'(lo_low), 32'd2);
        chk("lit_wr_we_hi", 32'(hi_low), 32'd2);
        chk("lit_wr_hold", 32'(g_we[3]), 32'h1);
        chk("lit_wr_dqoe", 32'(dqoe_sum), 32'd6);
        chk("lit_wr_rdy6", 32'(g_rdy[6]), 32'h0);
        chk("lit_wr_rdy7", 32'(g_rdy[7]), 32'h1);
        chk("lit_wr_rdata", g_rd[7], 32'h0);
        step(); wr1 = 0;
        step();

        // Read back.
        rd1 = 1; addr1 = 32'd1032;
        grab1();
        oe_low = 0; dqoe_sum = 0;
        for (int k = 0; k < 8; k++) begin oe_low += int'(!g_oe[k]); dqoe_sum += int'(g_dqoe[k]); end
        chk("lit_rd_data", g_rd[7], 32'hDEADBEEF);
        chk("lit_rd_rdy7", 32'(g_rdy[7]), 32'h1);
        chk("lit_rd_oe_cnt", 32'(oe_low), 32'd6);
        chk("lit_rd_oe0", 32'(g_oe[0]), 32'h1);
        chk("lit_rd_oe7", 32'(g_oe[7]), 32'h1);
        chk("lit_rd_dqoe", 32'(dqoe_sum), 32'd0);
        step();

        // Back-to-back write then read, request held across the boundary.
        wr1 = 1; rd1 = 0; addr1 = 32'd1036; wd1 = 32'hCAFEF00D;
        grab1();
        step(); wr1 = 0; rd1 = 1;
        grab1();
        chk("lit_b2b_idle_oe", 32'(g_oe[0]), 32'h1);
        chk("lit_b2b_lo_oe", 32'(g_oe[1]), 32'h0);
        chk("lit_b2b_rdy14", 32'(g_rdy[6]), 32'h0);
        chk("lit_b2b_rdy15", 32'(g_rdy[7]), 32'h1);
        chk("lit_b2b_data", g_rd[7], 32'hCAFEF00D);
        step();

        // Both enables -> write.
        wr1 = 1; rd1 = 1; addr1 = 32'd1044; wd1 = 32'h0BADF00D;
        grab1();
        chk("lit_both_dqoe", 32'(g_dqoe[1]), 32'h1);
        chk("lit_both_oe_n", 32'(g_oe[1]), 32'h1);
        step(); wr1 = 0;
        grab1();
        chk("lit_both_data", g_rd[7], 32'h0BADF00D);
        step(); rd1 = 0;
        step();

        // Reset in cycle 5 of a write; held request restarts.
        wr1 = 1; addr1 = 32'd1048; wd1 = 32'h13579BDF;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("lit_mid_we_n", 32'(wen1), 32'h1);
        chk("lit_mid_dqoe", 32'(dqoe1), 32'h0);
        chk("lit_mid_addr", 32'(sa1), 32'h0);
        step(); rst = 0;
        grab1();
        chk("lit_mid_rdy0", 32'(g_rdy[0]), 32'h0);
        chk("lit_mid_rdy6", 32'(g_rdy[6]), 32'h0);
        chk("lit_mid_rdy7", 32'(g_rdy[7]), 32'h1);
        step(); wr1 = 0; rd1 = 1;
        grab1();
        chk("lit_mid_data", g_rd[7], 32'h13579BDF);
        step(); rd1 = 0;
        step();

        // Randomized traffic, checked cycle by cycle by the compare process.
        for (int t = 0; t < 200; t++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            wr1 = (sel < 4) || (sel == 8);
            rd1 = !wr1 || (sel == 8);
            addr1 = ($urandom_range(0, 9) == 0) ? ($urandom & ~32'd3)
                                                : 32'd1024 + 32'd4 * $urandom_range(0, 15);
            wd1 = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1; wr1 = 0; rd1 = 0;
                repeat (9) @(posedge clk);
                #1;
            end else begin
                wait_ready1();
                step();
                if ($urandom_range(0, 3) == 0) begin wr1 = 0; rd1 = 0; step(); end
            end
        end
        wr1 = 0; rd1 = 0;
        repeat (10) step();

        // Zero wait cycles, address below the base wraps to the top SRAM word.
        wr0 = 1; addr0 = 32'd1020; wd0 = 32'h12345678;
        grab0();
        chk("lit_z_addr_lo", 32'(g_a[1]), 32'h3FFFE);
        chk("lit_z_dq_lo", 32'(g_dq[1]), 32'h5678);
        chk("lit_z_addr_hi", 32'(g_a[3]), 32'h3FFFF);
        chk("lit_z_dq_hi", 32'(g_dq[3]), 32'h1234);
        chk("lit_z_we1", 32'(g_we[1]), 32'h0);
        chk("lit_z_we2", 32'(g_we[2]), 32'h1);
        chk("lit_z_wrdy4", 32'(g_rdy[4]), 32'h0);
        chk("lit_z_wrdy5", 32'(g_rdy[5]), 32'h1);
        step(); wr0 = 0; rd0 = 1;
        grab0();
        chk("lit_z_roe1", 32'(g_oe[1]), 32'h0);
        chk("lit_z_rrdy4", 32'(g_rdy[4]), 32'h0);
        chk("lit_z_rrdy5", 32'(g_rdy[5]), 32'h1);
        chk("lit_z_rdata", g_rd[5], 32'h12345678);
        chk("lit_z_mem", 32'(mem0[18'h3FFFE]), 32'h5678);
        step(); rd0 = 0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
